// File: rtl/hash160_pkg.sv
// Shared types and constants for the Hash160 (RIPEMD-160 of SHA-256) sequencer.
package hash160_pkg;

  localparam logic [7:0] START_BYTE_DEF = 8'hAA;
  localparam int         MSG_BYTES_DEF  = 64;

  // Second SHA-256 block for a 64-byte message: 0x80, 55 zero bytes, bit length 512 big-endian.
  localparam logic [511:0] SHA_PAD_BLOCK = {8'h80, 440'h0, 64'h0000_0000_0000_0200};

  // Tail after the 32-byte digest: 0x80, 23 zero bytes, bit length 256 little-endian.
  localparam logic [255:0] RMD_PAD_TAIL = {8'h80, 184'h0, 64'h0001_0000_0000_0000};

  typedef enum logic [3:0] {
    IDLE,
    COLLECT,
    SHA1,
    SHA1_WAIT,
    SHA2,
    SHA2_WAIT,
    RMD,
    RMD_WAIT,
    DONE
  } state_e;

  function automatic logic is_busy(input state_e s);
    return !(s == IDLE || s == DONE);
  endfunction

endpackage

// File: rtl/hash160_msg_buf.sv
// Message fill buffer: byte idx lands at [511-8*idx -: 8]; clear zeroes the whole block.
module hash160_msg_buf (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic [5:0]   idx,
  input  logic [7:0]   din,
  output logic [511:0] data
);

  logic [511:0] data_q;
  logic [511:0] data_d;

  always_comb begin
    data_d = data_q;
    if (clear) begin
      data_d = '0;
    end else if (load) begin
      // Byte idx sits 8*(63-idx) bits above the LSB, i.e. base {~idx, 3'b000}.
      data_d[{~idx, 3'b000} +: 8] = din;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/hash160_ctrl.sv
// Hash160 sequencer: collects a framed message, drives SHA-256 twice, then RIPEMD-160 once.
module hash160_ctrl
  import hash160_pkg::*;
#(
  parameter logic [7:0] START_BYTE = START_BYTE_DEF,
  parameter int         MSG_BYTES  = MSG_BYTES_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   i_text,
  output logic         o_busy,
  output logic         o_valid,
  output logic [159:0] o_answer,
  input  logic         sha_ready,
  output logic         sha_init,
  output logic         sha_next,
  output logic [511:0] sha_block,
  input  logic         sha_valid,
  input  logic [255:0] sha_digest,
  input  logic         rmd_ready,
  output logic         rmd_init,
  output logic [511:0] rmd_block,
  input  logic         rmd_valid,
  input  logic [159:0] rmd_digest
);

  localparam logic [5:0] LAST_IDX = 6'(MSG_BYTES - 1);

  state_e         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;
  logic [159:0]   answer_q, answer_d;
  logic [255:0]   digest_q, digest_d;
  logic           buf_clear;
  logic           buf_load;
  logic [511:0]   msg_block;

  hash160_msg_buf u_msg_buf (
    .clk   (clk),
    .clear (buf_clear),
    .load  (buf_load),
    .idx   (cnt_q),
    .din   (i_text),
    .data  (msg_block)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    answer_d  = answer_q;
    digest_d  = digest_q;
    buf_clear = 1'b0;
    buf_load  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (i_text == START_BYTE) begin
          state_d   = COLLECT;
          cnt_d     = '0;
          valid_d   = 1'b0;
          buf_clear = 1'b1;
        end
      end
      COLLECT: begin
        // Every byte is payload here, including START_BYTE.
        buf_load = 1'b1;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == LAST_IDX) state_d = SHA1;
      end
      SHA1:      if (sha_ready) state_d = SHA1_WAIT;
      SHA1_WAIT: if (sha_valid) state_d = SHA2;
      SHA2:      if (sha_ready) state_d = SHA2_WAIT;
      SHA2_WAIT: begin
        if (sha_valid) begin
          digest_d = sha_digest;
          state_d  = RMD;
        end
      end
      RMD:       if (rmd_ready) state_d = RMD_WAIT;
      RMD_WAIT: begin
        if (rmd_valid) begin
          answer_d = rmd_digest;
          valid_d  = 1'b1;
          state_d  = DONE;
        end
      end
      default:   state_d = IDLE;
    endcase
    busy_d = is_busy(state_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      answer_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      answer_q <= answer_d;
    end
    digest_q <= digest_d;
  end

  // Strobes fire in the issuing state only while the core is ready; the state leaves on that cycle.
  assign sha_init = (state_q == SHA1) && sha_ready;
  assign sha_next = (state_q == SHA2) && sha_ready;
  assign rmd_init = (state_q == RMD)  && rmd_ready;

  // Blocks are gated to their issue/wait states so stale buffer contents never reach a core.
  always_comb begin
    sha_block = '0;
    if (state_q == SHA1 || state_q == SHA1_WAIT) sha_block = msg_block;
    else if (state_q == SHA2 || state_q == SHA2_WAIT) sha_block = SHA_PAD_BLOCK;
  end

  assign rmd_block = (state_q == RMD || state_q == RMD_WAIT) ? {digest_q, RMD_PAD_TAIL} : '0;

  assign o_busy   = busy_q;
  assign o_valid  = valid_q;
  assign o_answer = answer_q;

endmodule
